// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Main control FSM of the multicycle ARM core. Sequences the shared ALU, the
// unified memory port and the register file through fetch / decode / execute /
// writeback, waits on memory with a ready handshake, counts retired
// instructions and halts on an illegal Op or a memory timeout.
// Moore outputs are registered from the next state so they line up with the
// state register; IRWrite/NextPC depend on mem_ready in FETCH and stay Mealy.
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active-low
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             ALUOp,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_ERROR  = 4'd11
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;

    logic               adr_src_q,    adr_src_d;
    logic               alu_src_a_q,  alu_src_a_d;
    logic [1:0]         alu_src_b_q,  alu_src_b_d;
    logic [1:0]         result_src_q, result_src_d;
    logic               reg_w_q,      reg_w_d;
    logic               mem_w_q,      mem_w_d;
    logic               branch_q,     branch_d;
    logic               alu_op_q,     alu_op_d;
    logic               halted_q,     halted_d;

    logic               in_wait;
    logic               stalled;
    logic               timeout;
    logic               retire;

    // Next-state, wait counter and retire counter
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        instr_count_d = instr_count_q;

        in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        stalled = in_wait && !mem_ready;
        // ready on the last allowed cycle still completes the access
        timeout = stalled && (wait_cnt_q == WAIT_W'(MAX_WAIT));

        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_ERROR;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d = S_ERROR;
        end

        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (stalled) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        // an instruction retires when its final step hands back to FETCH
        retire = ((state_q == S_MEMWB) || (state_q == S_MEMWR) ||
                  (state_q == S_ALUWB) || (state_q == S_BRANCH)) && (state_d == S_FETCH);
        if (retire) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end
    end

    // Moore output decode of the state being entered
    always_comb begin
        adr_src_d    = 1'b0;
        alu_src_a_d  = 1'b0;
        alu_src_b_d  = 2'b00;
        result_src_d = 2'b00;
        reg_w_d      = 1'b0;
        mem_w_d      = 1'b0;
        branch_d     = 1'b0;
        alu_op_d     = 1'b0;
        halted_d     = 1'b0;
        case (state_d)
            S_FETCH, S_DECODE: begin
                alu_src_a_d  = 1'b1;
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
            end
            S_MEMADR: alu_src_b_d = 2'b01;
            S_MEMRD:  adr_src_d = 1'b1;
            S_MEMWB: begin
                result_src_d = 2'b01;
                reg_w_d      = 1'b1;
            end
            S_MEMWR: begin
                adr_src_d = 1'b1;
                mem_w_d   = 1'b1;
            end
            S_EXECR:  alu_op_d = 1'b1;
            S_EXECI: begin
                alu_src_b_d = 2'b01;
                alu_op_d    = 1'b1;
            end
            S_ALUWB:  reg_w_d = 1'b1;
            S_BRANCH: begin
                alu_src_b_d  = 2'b01;
                result_src_d = 2'b10;
                branch_d     = 1'b1;
            end
            S_ERROR:  halted_d = 1'b1;
            default: ;
        endcase
    end

    // State, counters and registered outputs; reset returns to IDLE at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
            adr_src_q     <= 1'b0;
            alu_src_a_q   <= 1'b0;
            alu_src_b_q   <= 2'b00;
            result_src_q  <= 2'b00;
            reg_w_q       <= 1'b0;
            mem_w_q       <= 1'b0;
            branch_q      <= 1'b0;
            alu_op_q      <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
            adr_src_q     <= adr_src_d;
            alu_src_a_q   <= alu_src_a_d;
            alu_src_b_q   <= alu_src_b_d;
            result_src_q  <= result_src_d;
            reg_w_q       <= reg_w_d;
            mem_w_q       <= mem_w_d;
            branch_q      <= branch_d;
            alu_op_q      <= alu_op_d;
            halted_q      <= halted_d;
        end
    end

    // Instruction load and PC update fire only on the cycle the fetch completes
    assign IRWrite     = (state_q == S_FETCH) && mem_ready;
    assign NextPC      = (state_q == S_FETCH) && mem_ready;
    assign AdrSrc      = adr_src_q;
    assign ALUSrcA     = alu_src_a_q;
    assign ALUSrcB     = alu_src_b_q;
    assign ResultSrc   = result_src_q;
    assign RegW        = reg_w_q;
    assign MemW        = mem_w_q;
    assign Branch      = branch_q;
    assign ALUOp       = alu_op_q;
    assign halted      = halted_q;
    assign instr_count = instr_count_q;

endmodule
